// File: rtl/tpu_host_arbiter_if.sv
// Host-side request/response bundle for the two requesters sharing the tpuv1 port.
interface tpu_host_arbiter_if #(
   parameter int unsigned ADDRW = 16,
   parameter int unsigned DATAW = 64
);
   logic             req0_valid;
   logic             req0_rw;
   logic [ADDRW-1:0] req0_addr;
   logic [DATAW-1:0] req0_wdata;
   logic             req0_ready;

   logic             req1_valid;
   logic             req1_rw;
   logic [ADDRW-1:0] req1_addr;
   logic [DATAW-1:0] req1_wdata;
   logic             req1_ready;

   logic             rsp0_valid;
   logic             rsp1_valid;
   logic [DATAW-1:0] rsp_rdata;

   modport master (
      output req0_valid, req0_rw, req0_addr, req0_wdata,
      output req1_valid, req1_rw, req1_addr, req1_wdata,
      input  req0_ready, req1_ready,
      input  rsp0_valid, rsp1_valid, rsp_rdata
   );

   modport slave (
      input  req0_valid, req0_rw, req0_addr, req0_wdata,
      input  req1_valid, req1_rw, req1_addr, req1_wdata,
      output req0_ready, req1_ready,
      output rsp0_valid, rsp1_valid, rsp_rdata
   );
endinterface

// File: rtl/tpu_host_arbiter.sv
// Round-robin arbiter/sequencer sharing the single tpuv1 bus between two host
// requesters; stalls all traffic while a started matrix multiply is running.
module tpu_host_arbiter #(
   parameter int unsigned       DIM         = 8,
   parameter int unsigned       ADDRW       = 16,
   parameter int unsigned       DATAW       = 64,
   parameter logic [ADDRW-1:0]  START_ADDR  = 16'h0400,
   parameter int unsigned       BUSY_CYCLES = 3 * DIM
) (
   input  logic                 clk,
   input  logic                 rst_n,
   tpu_host_arbiter_if.slave    host,
   output logic                 tpu_r_w,
   output logic [ADDRW-1:0]     tpu_addr,
   output logic [DATAW-1:0]     tpu_dataIn,
   input  logic [DATAW-1:0]     tpu_dataOut,
   output logic                 busy,
   output logic                 done
);

   localparam int unsigned CNTW = $clog2(BUSY_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_RDWAIT,
      S_RDRET,
      S_COMPUTE
   } state_t;

   state_t            state_q, state_d;
   logic [CNTW-1:0]   cnt_q, cnt_d;
   logic              last_grant_q, last_grant_d;
   logic              owner_q, owner_d;
   logic              grant0_c, grant1_c;
   logic              rsp0_valid_q, rsp1_valid_q;
   logic [DATAW-1:0]  rsp_rdata_q;

   // Winner selection: a lone requester wins, a tie goes to the one not granted last.
   always_comb begin
      grant0_c = 1'b0;
      grant1_c = 1'b0;
      if (state_q == S_IDLE) begin
         grant0_c = host.req0_valid && (!host.req1_valid ||  last_grant_q);
         grant1_c = host.req1_valid && (!host.req0_valid || !last_grant_q);
      end
   end

   assign host.req0_ready = grant0_c;
   assign host.req1_ready = grant1_c;
   assign host.rsp0_valid = rsp0_valid_q;
   assign host.rsp1_valid = rsp1_valid_q;
   assign host.rsp_rdata  = rsp_rdata_q;

   // Next-state logic; the issued op is read back from the registered bus in ISSUE.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      last_grant_d = last_grant_q;
      owner_d      = owner_q;
      case (state_q)
         S_IDLE: begin
            if (grant0_c || grant1_c) begin
               state_d      = S_ISSUE;
               owner_d      = grant1_c;
               last_grant_d = grant1_c;
            end
         end
         S_ISSUE: begin
            if (!tpu_r_w) begin
               state_d = S_RDWAIT;
            end else if (tpu_addr == START_ADDR) begin
               state_d = S_COMPUTE;
               cnt_d   = CNTW'(BUSY_CYCLES - 1);
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RDWAIT:  state_d = S_RDRET;
         S_RDRET:   state_d = S_IDLE;
         S_COMPUTE: begin
            if (cnt_q == '0) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - CNTW'(1);
            end
         end
         default:   state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         last_grant_q <= 1'b1;
         owner_q      <= 1'b0;
         tpu_r_w      <= 1'b0;
         tpu_addr     <= '0;
         tpu_dataIn   <= '0;
         rsp_rdata_q  <= '0;
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         last_grant_q <= last_grant_d;
         owner_q      <= owner_d;

         // Bus carries the accepted op for the ISSUE cycle only, idle value otherwise.
         tpu_r_w    <= 1'b0;
         tpu_addr   <= '0;
         tpu_dataIn <= '0;
         if (grant0_c) begin
            tpu_r_w    <= host.req0_rw;
            tpu_addr   <= host.req0_addr;
            tpu_dataIn <= host.req0_wdata;
         end else if (grant1_c) begin
            tpu_r_w    <= host.req1_rw;
            tpu_addr   <= host.req1_addr;
            tpu_dataIn <= host.req1_wdata;
         end

         if (state_q == S_RDWAIT) begin
            rsp_rdata_q <= tpu_dataOut;
         end

         rsp0_valid_q <= (state_d == S_RDRET) && !owner_q;
         rsp1_valid_q <= (state_d == S_RDRET) &&  owner_q;
         busy         <= (state_d != S_IDLE);
         done         <= (state_d == S_COMPUTE) && (cnt_d == '0);
      end
   end

endmodule

// File: tb/tb_tpu_host_arbiter.sv
// Bench for tpu_host_arbiter: directed sequences, an arbitration table, and a
// randomized run against a transaction-level timeline model with a tpuv1 memory stand-in.
module tb_tpu_host_arbiter;
   localparam int unsigned DIM   = 8;
   localparam int unsigned ADDRW = 16;
   localparam int unsigned DATAW = 64;
   localparam int          BUSY  = 3 * DIM;
   localparam logic [15:0] START = 16'h0400;
   localparam int          NCYC  = 1500;
   localparam int          NEXP  = NCYC + BUSY + 16;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             tpu_r_w;
   logic [15:0]      tpu_addr;
   logic [63:0]      tpu_dataIn;
   logic [63:0]      tpu_dataOut;
   logic             busy;
   logic             done;

   tpu_host_arbiter_if #(.ADDRW(ADDRW), .DATAW(DATAW)) hif ();

   tpu_host_arbiter #(
      .DIM(DIM), .ADDRW(ADDRW), .DATAW(DATAW),
      .START_ADDR(START), .BUSY_CYCLES(BUSY)
   ) dut (
      .clk(clk), .rst_n(rst_n), .host(hif),
      .tpu_r_w(tpu_r_w), .tpu_addr(tpu_addr), .tpu_dataIn(tpu_dataIn),
      .tpu_dataOut(tpu_dataOut), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // tpuv1 stand-in: registered read (data valid the cycle after the bus), write on bus.
   logic [63:0] smem [0:4095];
   logic        stub_clr = 1'b0;
   logic        pre_we = 1'b0;
   logic [15:0] pre_addr = '0;
   logic [63:0] pre_data = '0;
   always @(posedge clk) begin
      tpu_dataOut <= smem[tpu_addr[11:0]];
      if (stub_clr) begin
         for (int i = 0; i < 4096; i++) smem[i] <= '0;
      end else begin
         if (tpu_r_w) smem[tpu_addr[11:0]] <= tpu_dataIn;
         if (pre_we)  smem[pre_addr[11:0]] <= pre_data;
      end
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int n, input logic v, input logic rw,
                        input logic [15:0] a, input logic [63:0] d);
      if (n == 0) begin
         hif.req0_valid = v; hif.req0_rw = rw; hif.req0_addr = a; hif.req0_wdata = d;
      end else begin
         hif.req1_valid = v; hif.req1_rw = rw; hif.req1_addr = a; hif.req1_wdata = d;
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " ready0"}, 64'(hif.req0_ready), 0);
      check({tag, " ready1"}, 64'(hif.req1_ready), 0);
      check({tag, " rsp0"},   64'(hif.rsp0_valid), 0);
      check({tag, " rsp1"},   64'(hif.rsp1_valid), 0);
      check({tag, " rdata"},  hif.rsp_rdata, 0);
      check({tag, " r_w"},    64'(tpu_r_w), 0);
      check({tag, " addr"},   64'(tpu_addr), 0);
      check({tag, " din"},    tpu_dataIn, 0);
      check({tag, " busy"},   64'(busy), 0);
      check({tag, " done"},   64'(done), 0);
   endtask

   typedef struct {
      logic v0;
      logic v1;
      logic r0;
      logic r1;
   } arb_vec_t;

   typedef struct {
      logic        v;
      logic        rw;
      logic [15:0] a;
      logic [63:0] d;
   } req_t;

   arb_vec_t    tbl [10];
   req_t        p [2];
   req_t        op;
   logic [15:0] pool [5];
   logic [63:0] mmem [0:4095];

   logic        e_rw    [NEXP];
   logic [15:0] e_addr  [NEXP];
   logic [63:0] e_din   [NEXP];
   logic        e_rsp0  [NEXP];
   logic        e_rsp1  [NEXP];
   logic        e_busy  [NEXP];
   logic        e_done  [NEXP];
   logic        e_rdset [NEXP];
   logic [63:0] e_rdat  [NEXP];

   initial begin
      int          free_at;
      logic        lg, idle, g0, g1, w;
      logic [63:0] exp_rdata;
      logic [15:0] ea;
      int          r;

      drive(0, 0, 0, '0, '0);
      drive(1, 0, 0, '0, '0);
      stub_clr = 1'b1;
      rst_n    = 1'b0;
      repeat (2) @(posedge clk);
      #1 stub_clr = 1'b0;
      check_all_zero("reset");
      rst_n = 1'b1;

      // Single write: bus valid for exactly A+1.
      tick();
      drive(0, 1, 1, 16'h0100, 64'h0807060504030201);
      #1;
      check("s1 ready0 A", 64'(hif.req0_ready), 1);
      check("s1 ready1 A", 64'(hif.req1_ready), 0);
      tick();
      drive(0, 0, 0, '0, '0);
      #1;
      check("s1 r_w A+1",  64'(tpu_r_w), 1);
      check("s1 addr A+1", 64'(tpu_addr), 64'h100);
      check("s1 din A+1",  tpu_dataIn, 64'h0807060504030201);
      check("s1 busy A+1", 64'(busy), 1);
      tick();
      #1;
      check("s1 r_w A+2",  64'(tpu_r_w), 0);
      check("s1 addr A+2", 64'(tpu_addr), 0);
      check("s1 din A+2",  tpu_dataIn, 0);

      // Arbitration table; req0 won last, so the first tie goes to req1.
      tbl[0] = '{1, 1, 0, 1};
      tbl[1] = '{1, 1, 1, 0};
      tbl[2] = '{0, 1, 0, 1};
      tbl[3] = '{1, 1, 1, 0};
      tbl[4] = '{1, 0, 1, 0};
      tbl[5] = '{1, 1, 0, 1};
      tbl[6] = '{0, 0, 0, 0};
      tbl[7] = '{1, 1, 1, 0};
      tbl[8] = '{0, 1, 0, 1};
      tbl[9] = '{1, 1, 1, 0};
      for (int i = 0; i < 10; i++) begin
         tick();
         drive(0, tbl[i].v0, 1, 16'(16'h0500 + i * 8), 64'(i));
         drive(1, tbl[i].v1, 1, 16'(16'h0580 + i * 8), 64'(100 + i));
         #1;
         check($sformatf("tbl[%0d] ready0", i), 64'(hif.req0_ready), 64'(tbl[i].r0));
         check($sformatf("tbl[%0d] ready1", i), 64'(hif.req1_ready), 64'(tbl[i].r1));
         tick();
         drive(0, 0, 0, '0, '0);
         drive(1, 0, 0, '0, '0);
         #1;
         ea = tbl[i].r0 ? 16'(16'h0500 + i * 8) : (tbl[i].r1 ? 16'(16'h0580 + i * 8) : 16'h0);
         check($sformatf("tbl[%0d] bus addr", i), 64'(tpu_addr), 64'(ea));
      end

      // req1 read returns to req1 only, data at A+3.
      tick();
      pre_addr = 16'h0300;
      pre_data = 64'hDEAD;
      pre_we   = 1'b1;
      tick();
      pre_we = 1'b0;
      drive(1, 1, 0, 16'h0300, '0);
      #1;
      check("s2 ready1 A", 64'(hif.req1_ready), 1);
      check("s2 ready0 A", 64'(hif.req0_ready), 0);
      tick();
      drive(1, 0, 0, '0, '0);
      #1;
      check("s2 r_w A+1",  64'(tpu_r_w), 0);
      check("s2 addr A+1", 64'(tpu_addr), 64'h300);
      check("s2 busy A+1", 64'(busy), 1);
      tick();
      #1;
      check("s2 rsp1 A+2", 64'(hif.rsp1_valid), 0);
      tick();
      #1;
      check("s2 rsp1 A+3",  64'(hif.rsp1_valid), 1);
      check("s2 rsp0 A+3",  64'(hif.rsp0_valid), 0);
      check("s2 rdata A+3", hif.rsp_rdata, 64'hDEAD);
      tick();
      #1;
      check("s2 rsp1 A+4",  64'(hif.rsp1_valid), 0);
      check("s2 rdata hold", hif.rsp_rdata, 64'hDEAD);

      // Start: busy through A+1+BUSY, done in A+1+BUSY, held req1 granted at A+2+BUSY.
      tick();
      drive(0, 1, 1, START, '0);
      drive(1, 1, 0, 16'h0300, '0);
      #1;
      check("s3 ready0 A", 64'(hif.req0_ready), 1);
      check("s3 ready1 A", 64'(hif.req1_ready), 0);
      check("s3 busy A",   64'(busy), 0);
      for (int k = 1; k <= BUSY + 2; k++) begin
         tick();
         if (k == 1) drive(0, 0, 0, '0, '0);
         #1;
         check($sformatf("s3 busy A+%0d", k),   64'(busy), 64'(k <= BUSY + 1));
         check($sformatf("s3 done A+%0d", k),   64'(done), 64'(k == BUSY + 1));
         check($sformatf("s3 ready1 A+%0d", k), 64'(hif.req1_ready), 64'(k == BUSY + 2));
      end
      tick();
      drive(1, 0, 0, '0, '0);
      repeat (3) tick();

      // Asynchronous reset during COMPUTE, then req0 wins the first tie.
      tick();
      drive(0, 1, 1, START, '0);
      #1;
      check("s4 ready0 A", 64'(hif.req0_ready), 1);
      tick();
      drive(0, 0, 0, '0, '0);
      repeat (4) tick();
      #1;
      check("s4 busy pre-reset", 64'(busy), 1);
      rst_n = 1'b0;
      #1;
      check_all_zero("s4 mid-reset");
      tick();
      rst_n = 1'b1;
      tick();
      drive(0, 1, 1, 16'h0108, 64'h1);
      drive(1, 1, 1, 16'h0200, 64'h2);
      #1;
      check("s4 ready0 tie", 64'(hif.req0_ready), 1);
      check("s4 ready1 tie", 64'(hif.req1_ready), 0);
      tick();
      drive(0, 0, 0, '0, '0);
      drive(1, 0, 0, '0, '0);
      tick();

      // Randomized run against the timeline model.
      pool[0] = 16'h0100; pool[1] = 16'h0108; pool[2] = 16'h0200;
      pool[3] = 16'h0300; pool[4] = 16'h07F8;
      for (int i = 0; i < 4096; i++) mmem[i] = '0;
      for (int i = 0; i < NEXP; i++) begin
         e_rw[i] = 0; e_addr[i] = '0; e_din[i] = '0; e_rsp0[i] = 0; e_rsp1[i] = 0;
         e_busy[i] = 0; e_done[i] = 0; e_rdset[i] = 0; e_rdat[i] = '0;
      end
      p[0] = '{0, 0, '0, '0};
      p[1] = '{0, 0, '0, '0};
      rst_n    = 1'b0;
      stub_clr = 1'b1;
      tick();
      rst_n    = 1'b1;
      stub_clr = 1'b0;
      free_at   = 0;
      lg        = 1'b1;
      exp_rdata = '0;

      for (int c = 0; c < NCYC; c++) begin
         tick();
         for (int i = 0; i < 2; i++) begin
            if (!p[i].v && $urandom_range(0, 2) != 0) begin
               r       = int'($urandom_range(0, 15));
               p[i].v  = 1'b1;
               p[i].rw = 1'($urandom_range(0, 1));
               p[i].a  = (r == 0) ? START : pool[r % 5];
               p[i].d  = {$urandom, $urandom};
            end
            drive(i, p[i].v, p[i].rw, p[i].a, p[i].d);
         end
         #1;
         idle = (c >= free_at);
         g0   = idle && p[0].v && (!p[1].v ||  lg);
         g1   = idle && p[1].v && (!p[0].v || !lg);
         if (e_rdset[c]) exp_rdata = e_rdat[c];
         check($sformatf("rnd c%0d ready0", c), 64'(hif.req0_ready), 64'(g0));
         check($sformatf("rnd c%0d ready1", c), 64'(hif.req1_ready), 64'(g1));
         check($sformatf("rnd c%0d r_w", c),    64'(tpu_r_w), 64'(e_rw[c]));
         check($sformatf("rnd c%0d addr", c),   64'(tpu_addr), 64'(e_addr[c]));
         check($sformatf("rnd c%0d din", c),    tpu_dataIn, e_din[c]);
         check($sformatf("rnd c%0d rsp0", c),   64'(hif.rsp0_valid), 64'(e_rsp0[c]));
         check($sformatf("rnd c%0d rsp1", c),   64'(hif.rsp1_valid), 64'(e_rsp1[c]));
         check($sformatf("rnd c%0d rdata", c),  hif.rsp_rdata, exp_rdata);
         check($sformatf("rnd c%0d busy", c),   64'(busy), 64'(e_busy[c]));
         check($sformatf("rnd c%0d done", c),   64'(done), 64'(e_done[c]));
         if (g0 || g1) begin
            w  = g1;
            lg = g1;
            op = p[w];
            p[w].v = 1'b0;
            e_rw[c + 1]   = op.rw;
            e_addr[c + 1] = op.a;
            e_din[c + 1]  = op.d;
            if (op.rw) begin
               mmem[op.a[11:0]] = op.d;
               if (op.a == START) begin
                  free_at = c + 2 + BUSY;
                  e_done[c + 1 + BUSY] = 1'b1;
               end else begin
                  free_at = c + 2;
               end
            end else begin
               free_at = c + 4;
               if (w) e_rsp1[c + 3] = 1'b1;
               else   e_rsp0[c + 3] = 1'b1;
               e_rdset[c + 3] = 1'b1;
               e_rdat[c + 3]  = mmem[op.a[11:0]];
            end
            for (int k = c + 1; k < free_at; k++) e_busy[k] = 1'b1;
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
